// File: rtl/bin_decoder_scan.sv
// rtl/bin_decoder_scan.sv - N-bit binary to one-hot decoder with registered outputs and auto-scan
//
// Purpose: decodes bin_in to a one-hot select (direct mode) or walks the active
// channel through 0..LAST_IDX, holding each for PRESCALE clocks (scan mode).
// Optional build macro: BIN_DECODER_SCAN_BLANK_EN blanks one_hot_out during the
// cycle in which step is high (break-before-make between scanned channels).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   en           in   global enable, 0 forces one_hot_out low
//   mode         in   0 = direct decode, 1 = auto-scan
//   bin_in       in   N-bit select, direct mode only
//   one_hot_out  out  2**N registered one-hot (or all-zero) select
//   idx_out      out  N-bit registered current channel index
//   step         out  one-cycle pulse when the scan index advances
//   wrap         out  one-cycle pulse when the scan index wraps LAST_IDX -> 0
module bin_decoder_scan #(
  parameter int N        = 2,
  parameter int PRESCALE = 4,
  parameter int LAST_IDX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      bin_in,
  output logic [(1<<N)-1:0] one_hot_out,
  output logic [N-1:0]      idx_out,
  output logic              step,
  output logic              wrap
);

  localparam int OW = 1 << N;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  LAST  = N'(LAST_IDX);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [OW-1:0]   one_hot_q, one_hot_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;
  logic [N-1:0]    idx_next_scan;

  function automatic logic [OW-1:0] dec(input logic [N-1:0] sel);
    logic [OW-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      idx_q     <= '0;
      one_hot_q <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      one_hot_q <= one_hot_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
    end
  end

  // Next state depends only on en/mode; SCAN entry vs. continuation is
  // distinguished in the output process by looking at state_q.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = DIRECT;
    end else begin
      state_d = SCAN;
    end
  end

  assign idx_next_scan = (idx_q == LAST) ? '0 : idx_q + N'(1);

  // Next values of the datapath registers. pcnt defaults to 0 so any leave of
  // SCAN (or SCAN entry) discards a partial dwell.
  always_comb begin
    pcnt_d    = '0;
    idx_d     = idx_q;
    one_hot_d = one_hot_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    if (!en) begin
      one_hot_d = '0;
    end else if (!mode) begin
      // Channels beyond LAST_IDX are not addressable: blank and keep idx
      if (bin_in <= LAST) begin
        idx_d     = bin_in;
        one_hot_d = dec(bin_in);
      end else begin
        one_hot_d = '0;
      end
    end else if (state_q != SCAN) begin
      // Scan resumes from whatever channel was last selected
      one_hot_d = dec(idx_q);
    end else if (pcnt_q != PLAST) begin
      pcnt_d = pcnt_q + PW'(1);
`ifdef BIN_DECODER_SCAN_BLANK_EN
      // Relights the channel after the blanked step cycle; otherwise a no-op
      one_hot_d = dec(idx_q);
`endif
    end else begin
      step_d = 1'b1;
      wrap_d = (idx_q == LAST);
      idx_d  = idx_next_scan;
`ifdef BIN_DECODER_SCAN_BLANK_EN
      one_hot_d = '0;
`else
      one_hot_d = dec(idx_next_scan);
`endif
    end
  end

  assign one_hot_out = one_hot_q;
  assign idx_out     = idx_q;
  assign step        = step_q;
  assign wrap        = wrap_q;

endmodule
